// File: rtl/onchip_mem_stream_reader.sv
// Streams a programmed range of on-chip RAM words out as an Avalon-ST packet.
// A small FIFO absorbs the one-cycle RAM read latency and provides backpressure slack.
module onchip_mem_stream_reader #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    input  logic              csr_read,
    output logic [31:0]       csr_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_startofpacket,
    output logic              st_endofpacket,
    output logic              irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_start;
    logic [ADDR_W:0]     r_len;
    logic                r_irqEn;
    logic                r_done;
    logic [ADDR_W-1:0]   r_addrCtr;
    logic [ADDR_W:0]     r_issueRem;
    logic [ADDR_W:0]     r_beatRem;
    logic                r_inflight;
    logic                r_sop;
    logic [DATA_W-1:0]   r_fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wrPtr;
    logic [PTR_W-1:0]    r_rdPtr;
    logic [CNT_W-1:0]    r_fifoCount;

    logic                w_busy;
    logic                w_go;
    logic                w_start;
    logic                w_zeroDone;
    logic [CNT_W-1:0]    w_occupancy;
    logic                w_issue;
    logic                w_valid;
    logic                w_pop;
    logic                w_last;
    logic                w_csrWrStart;
    logic                w_csrWrLen;
    logic                w_csrWrCtrl;
    logic                w_csrWrStatus;

    assign w_busy        = (r_state != IDLE);
    assign w_csrWrStart  = csr_write && (csr_address == 2'd0);
    assign w_csrWrLen    = csr_write && (csr_address == 2'd1);
    assign w_csrWrCtrl   = csr_write && (csr_address == 2'd2);
    assign w_csrWrStatus = csr_write && (csr_address == 2'd3);
    assign w_go          = w_csrWrCtrl && csr_writedata[0];
    assign w_start       = w_go && !w_busy && (r_len != '0);
    assign w_zeroDone    = w_go && !w_busy && (r_len == '0);

    // The in-flight read already owns a FIFO slot, so counting it prevents overflow.
    assign w_occupancy = r_fifoCount + CNT_W'(r_inflight);
    assign w_issue     = (r_state == RUN) && (r_issueRem != '0) &&
                         (w_occupancy < CNT_W'(FIFO_DEPTH));
    assign w_valid     = (r_fifoCount != '0);
    assign w_pop       = w_valid && st_ready;
    assign w_last      = w_pop && (r_beatRem == (ADDR_W+1)'(1));

    assign mem_address      = r_addrCtr;
    assign mem_chipselect   = w_issue;
    assign mem_write        = 1'b0;
    assign mem_byteenable   = 4'hF;
    assign st_valid         = w_valid;
    assign st_data          = w_valid ? r_fifoMem[r_rdPtr] : '0;
    assign st_startofpacket = w_valid && r_sop;
    assign st_endofpacket   = w_valid && (r_beatRem == (ADDR_W+1)'(1));
    assign irq              = r_done && r_irqEn;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_start) w_nextState = RUN;
            RUN:     if (w_last) w_nextState = IDLE;
                     else if (r_issueRem == '0) w_nextState = DRAIN;
            DRAIN:   if (w_last) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addrCtr  <= '0;
            r_issueRem <= '0;
            r_beatRem  <= '0;
            r_inflight <= 1'b0;
            r_sop      <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_start) begin
                r_addrCtr  <= r_start;
                r_issueRem <= r_len;
                r_beatRem  <= r_len;
                r_sop      <= 1'b1;
            end else begin
                if (w_issue) begin
                    r_addrCtr  <= r_addrCtr + ADDR_W'(1);
                    r_issueRem <= r_issueRem - (ADDR_W+1)'(1);
                end
                if (w_pop) begin
                    r_beatRem <= r_beatRem - (ADDR_W+1)'(1);
                    r_sop     <= 1'b0;
                end
            end
        end
    end

    // RAM data returns the cycle after each issue and is pushed unconditionally.
    always_ff @(posedge clk) begin
        if (r_inflight) begin
            r_fifoMem[r_wrPtr] <= mem_readdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_fifoCount <= '0;
        end else begin
            if (r_inflight) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_pop)      r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({r_inflight, w_pop})
                2'b10:   r_fifoCount <= r_fifoCount + CNT_W'(1);
                2'b01:   r_fifoCount <= r_fifoCount - CNT_W'(1);
                default: r_fifoCount <= r_fifoCount;
            endcase
        end
    end

    // DONE set takes priority over a same-cycle software clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start <= '0;
            r_len   <= '0;
            r_irqEn <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_csrWrStart && !w_busy) r_start <= csr_writedata[ADDR_W-1:0];
            if (w_csrWrLen && !w_busy) begin
                if (csr_writedata > 32'(MAX_LEN)) r_len <= MAX_LEN;
                else                              r_len <= csr_writedata[ADDR_W:0];
            end
            if (w_csrWrCtrl) r_irqEn <= csr_writedata[1];
            if (w_last || w_zeroDone)                  r_done <= 1'b1;
            else if (w_start)                          r_done <= 1'b0;
            else if (w_csrWrStatus && csr_writedata[1]) r_done <= 1'b0;
        end
    end

    always_comb begin
        csr_readdata = '0;
        if (csr_read) begin
            case (csr_address)
                2'd0:    csr_readdata = {{(32-ADDR_W){1'b0}}, r_start};
                2'd1:    csr_readdata = {{(31-ADDR_W){1'b0}}, r_len};
                2'd2:    csr_readdata = {30'b0, r_irqEn, 1'b0};
                default: csr_readdata = {30'b0, r_done, w_busy};
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Directed bench for onchip_mem_stream_reader with a behavioural 256x32 RAM,
// a stream monitor/scoreboard and hand-computed expectations.
module tb_onchip_mem_stream_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  csr_address;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic        csr_read;
    logic [31:0] csr_readdata;
    logic [7:0]  mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic        st_startofpacket;
    logic        st_endofpacket;
    logic        irq;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] ram [256];
    logic [31:0] beatQ [$];
    logic        sopQ [$];
    logic        eopQ [$];
    int          popCycleQ [$];
    logic [7:0]  addrQ [$];
    int          cycle = 0;
    int          issuedCnt = 0;
    int          poppedCnt = 0;
    int          maxOutstanding = 0;
    int          validSeen = 0;
    int          lastPopCycle = -1;
    int          irqRiseCycle = -1;
    bit          holdPending = 0;
    logic [31:0] heldData = '0;
    bit          prevIrq = 0;

    onchip_mem_stream_reader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .csr_address      (csr_address),
        .csr_write        (csr_write),
        .csr_writedata    (csr_writedata),
        .csr_read         (csr_read),
        .csr_readdata     (csr_readdata),
        .mem_address      (mem_address),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_byteenable   (mem_byteenable),
        .mem_readdata     (mem_readdata),
        .st_data          (st_data),
        .st_valid         (st_valid),
        .st_ready         (st_ready),
        .st_startofpacket (st_startofpacket),
        .st_endofpacket   (st_endofpacket),
        .irq              (irq)
    );

    // Free-running clock and cycle counter used for latency measurements.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural RAM port: data valid the cycle after a chipselect.
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= ram[mem_address];
    end

    function automatic logic [31:0] ramVal(input int a);
        int w;
        w = a & 255;
        if (w >= 'h10 && w <= 'h13) return 32'hA0 + 32'(w - 'h10);
        return 32'h5A00_0000 | 32'(w);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Stream and request monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (holdPending) begin
                checkOutput("holdValid", 32'(st_valid), 32'd1);
                checkOutput("holdData", st_data, heldData);
            end
            if (mem_chipselect) begin
                addrQ.push_back(mem_address);
                checkOutput("noOverflow", 32'(issuedCnt - poppedCnt < 4), 32'd1);
                issuedCnt++;
            end
            if (issuedCnt - poppedCnt > maxOutstanding) maxOutstanding = issuedCnt - poppedCnt;
            if (st_valid) validSeen++;
            if (st_valid && st_ready) begin
                beatQ.push_back(st_data);
                sopQ.push_back(st_startofpacket);
                eopQ.push_back(st_endofpacket);
                popCycleQ.push_back(cycle);
                poppedCnt++;
                if (st_endofpacket) lastPopCycle = cycle;
            end
            if (irq && !prevIrq) irqRiseCycle = cycle;
            prevIrq     = irq;
            holdPending = st_valid && !st_ready;
            heldData    = st_data;
        end else begin
            holdPending = 0;
            prevIrq     = 0;
        end
    end

    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        @(posedge clk);
        #1;
        csr_write = 1'b0;
    endtask

    task automatic csrRead(input logic [1:0] a, output logic [31:0] d);
        csr_address = a;
        csr_read    = 1'b1;
        #1;
        d        = csr_readdata;
        csr_read = 1'b0;
    endtask

    task automatic resetQueues();
        beatQ.delete(); sopQ.delete(); eopQ.delete(); popCycleQ.delete(); addrQ.delete();
        issuedCnt = 0; poppedCnt = 0; maxOutstanding = 0; validSeen = 0;
        lastPopCycle = -1; irqRiseCycle = -1;
    endtask

    task automatic waitDone(input int budget, input bit toggle);
        logic [31:0] s;
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            if (toggle) st_ready = (n % 3 == 0);
            @(posedge clk);
            #1;
            csrRead(2'd3, s);
            done = s[1];
            n++;
        end
        checkOutput("doneInTime", 32'(done), 32'd1);
    endtask

    task automatic verifyPacket(input string tag, input int start, input int len);
        checkOutput({tag, "_beats"}, 32'(beatQ.size()), 32'(len));
        checkOutput({tag, "_issues"}, 32'(addrQ.size()), 32'(len));
        for (int k = 0; k < len; k++) begin
            if (k < beatQ.size()) begin
                checkOutput({tag, "_data"}, beatQ[k], ramVal(start + k));
                checkOutput({tag, "_sop"}, 32'(sopQ[k]), 32'(k == 0));
                checkOutput({tag, "_eop"}, 32'(eopQ[k]), 32'(k == len - 1));
            end
            if (k < addrQ.size()) checkOutput({tag, "_addr"}, 32'(addrQ[k]), 32'((start + k) & 255));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        for (int i = 0; i < 256; i++) ram[i] = ramVal(i);
        reset_n = 1'b0; csr_address = '0; csr_write = 0; csr_writedata = '0;
        csr_read = 0; st_ready = 1'b1; mem_readdata = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstValid", 32'(st_valid), 32'd0);
        checkOutput("rstCs", 32'(mem_chipselect), 32'd0);
        checkOutput("rstBe", 32'(mem_byteenable), 32'hF);
        checkOutput("rstIrq", 32'(irq), 32'd0);
        csrRead(2'd3, rd); checkOutput("rstStatus", rd, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic packet START=0x10 LEN=4");
        resetQueues();
        applyStimulus(2'd0, 32'h10);
        applyStimulus(2'd1, 32'd4);
        applyStimulus(2'd2, 32'h1);
        checkOutput("lat0Cs", 32'(mem_chipselect), 32'd1);
        checkOutput("lat0Valid", 32'(st_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("lat1Valid", 32'(st_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("lat2Valid", 32'(st_valid), 32'd1);
        checkOutput("lat2Data", st_data, 32'hA0);
        checkOutput("lat2Sop", 32'(st_startofpacket), 32'd1);
        waitDone(50, 0);
        verifyPacket("basic", 'h10, 4);
        if (popCycleQ.size() == 4) checkOutput("backToBack", 32'(popCycleQ[3] - popCycleQ[0]), 32'd3);
        else checkOutput("backToBackCount", 32'(popCycleQ.size()), 32'd4);
        csrRead(2'd3, rd); checkOutput("basicStatus", rd, 32'h2);

        $display("[TB] address wrap START=0xFE LEN=4");
        applyStimulus(2'd3, 32'h2);
        resetQueues();
        applyStimulus(2'd0, 32'hFE);
        applyStimulus(2'd2, 32'h1);
        waitDone(50, 0);
        verifyPacket("wrap", 'hFE, 4);

        $display("[TB] backpressure LEN=8");
        applyStimulus(2'd3, 32'h2);
        resetQueues();
        applyStimulus(2'd0, 32'h40);
        applyStimulus(2'd1, 32'd8);
        applyStimulus(2'd2, 32'h1);
        waitDone(200, 1);
        st_ready = 1'b1;
        verifyPacket("bp", 'h40, 8);
        checkOutput("bpMaxOutstanding", 32'(maxOutstanding), 32'd4);

        $display("[TB] zero-length and single-beat packets");
        applyStimulus(2'd3, 32'h2);
        resetQueues();
        applyStimulus(2'd1, 32'd0);
        applyStimulus(2'd2, 32'h1);
        csrRead(2'd3, rd); checkOutput("zeroDone", rd, 32'h2);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("zeroIssues", 32'(addrQ.size()), 32'd0);
        checkOutput("zeroValid", 32'(validSeen), 32'd0);
        applyStimulus(2'd1, 32'd300);
        csrRead(2'd1, rd); checkOutput("lenSaturate", rd, 32'd256);
        applyStimulus(2'd3, 32'h2);
        resetQueues();
        applyStimulus(2'd0, 32'h20);
        applyStimulus(2'd1, 32'd1);
        st_ready = 1'b0;
        applyStimulus(2'd2, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("singleValid", 32'(st_valid), 32'd1);
        st_ready = 1'b1;
        applyStimulus(2'd3, 32'h2);
        csrRead(2'd3, rd); checkOutput("setWinsClear", rd, 32'h2);
        verifyPacket("single", 'h20, 1);

        $display("[TB] irq and GO while busy");
        applyStimulus(2'd3, 32'h2);
        resetQueues();
        applyStimulus(2'd0, 32'h30);
        applyStimulus(2'd1, 32'd2);
        st_ready = 1'b0;
        applyStimulus(2'd2, 32'h3);
        repeat (4) @(posedge clk);
        #1;
        csrRead(2'd3, rd); checkOutput("busyStatus", rd, 32'h1);
        applyStimulus(2'd1, 32'd5);
        csrRead(2'd1, rd); checkOutput("lenLockedBusy", rd, 32'd2);
        applyStimulus(2'd2, 32'h3);
        st_ready = 1'b1;
        waitDone(50, 0);
        repeat (4) @(posedge clk);
        #1;
        verifyPacket("irq", 'h30, 2);
        checkOutput("irqHigh", 32'(irq), 32'd1);
        checkOutput("irqRiseCycle", 32'(irqRiseCycle), 32'(lastPopCycle + 1));
        applyStimulus(2'd3, 32'h2);
        checkOutput("irqCleared", 32'(irq), 32'd0);
        csrRead(2'd3, rd); checkOutput("doneCleared", rd, 32'h0);

        $display("[TB] reset mid-packet");
        resetQueues();
        applyStimulus(2'd0, 32'h50);
        applyStimulus(2'd1, 32'd8);
        applyStimulus(2'd2, 32'h1);
        for (int n = 0; n < 40 && beatQ.size() < 3; n++) begin
            @(posedge clk); #1;
        end
        checkOutput("beatsBeforeReset", 32'(beatQ.size()), 32'd3);
        reset_n = 1'b0;
        #1;
        checkOutput("abortValid", 32'(st_valid), 32'd0);
        checkOutput("abortCs", 32'(mem_chipselect), 32'd0);
        checkOutput("abortEop", 32'(st_endofpacket), 32'd0);
        checkOutput("abortData", st_data, 32'd0);
        checkOutput("abortAddr", 32'(mem_address), 32'd0);
        checkOutput("abortNoEop", 32'(eopQ.sum() with (int'(item))), 32'd0);
        csrRead(2'd0, rd); checkOutput("abortStart", rd, 32'd0);
        csrRead(2'd1, rd); checkOutput("abortLen", rd, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        resetQueues();
        applyStimulus(2'd0, 32'h60);
        applyStimulus(2'd1, 32'd2);
        applyStimulus(2'd2, 32'h1);
        waitDone(50, 0);
        repeat (3) @(posedge clk);
        #1;
        verifyPacket("afterReset", 'h60, 2);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
